// File: rtl/stage5_field_extract_pkg.sv
// Shared constants and types for the stage-5 field extractor.
// Optional hit counters are enabled by defining STAGE5_HIT_CNT_EN.
package stage5_field_extract_pkg;

    // Message format defaults
    localparam int unsigned MAX_MESSAGE_BITS          = 64;
    localparam int unsigned MESSAGE_MUX_CONTROL_WIDTH = 4;
    localparam int unsigned FIELD_OS2_BITS            = 8;
    localparam int unsigned Q_OS2_E                   = 16;

    localparam logic [MESSAGE_MUX_CONTROL_WIDTH-1:0] MESSAGE_MUX_Q = 4'h5;
    localparam logic [FIELD_OS2_BITS-1:0]            DEFAUT_INFOR  = 8'h00;

    // Skid buffer occupancy codes
    localparam logic [1:0] STAGE5_BUF_EMPTY = 2'd0;
    localparam logic [1:0] STAGE5_BUF_ONE   = 2'd1;
    localparam logic [1:0] STAGE5_BUF_TWO   = 2'd2;

    typedef enum logic [1:0] {
        BUF_EMPTY = STAGE5_BUF_EMPTY,
        BUF_ONE   = STAGE5_BUF_ONE,
        BUF_TWO   = STAGE5_BUF_TWO
    } buf_state_e;

    localparam int unsigned          HIT_CNT_W   = 16;
    localparam logic [HIT_CNT_W-1:0] HIT_CNT_MAX = 16'hFFFF;

    function automatic logic [HIT_CNT_W-1:0] sat_inc(input logic [HIT_CNT_W-1:0] v);
        return (v == HIT_CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/stage5_field_extract_ch.sv
// One channel: field extraction into a 2-entry skid buffer, plus the
// optional saturating hit counter (STAGE5_HIT_CNT_EN).
module stage5_field_extract_ch
    import stage5_field_extract_pkg::*;
#(
    parameter int unsigned         MSG_BITS    = MAX_MESSAGE_BITS,
    parameter int unsigned         CTRL_W      = MESSAGE_MUX_CONTROL_WIDTH,
    parameter int unsigned         FIELD_W     = FIELD_OS2_BITS,
    parameter int unsigned         FIELD_LSB   = Q_OS2_E,
    parameter logic [CTRL_W-1:0]   MATCH_CODE  = MESSAGE_MUX_Q,
    parameter logic [FIELD_W-1:0]  DEFAULT_VAL = DEFAUT_INFOR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MSG_BITS-1:0] message,
    input  logic [CTRL_W-1:0]   mux_control,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [FIELD_W-1:0]  field,
    output logic                out_hit
`ifdef STAGE5_HIT_CNT_EN
    ,
    input  logic                 cnt_clr,
    output logic [HIT_CNT_W-1:0] hit_cnt
`endif
);

    buf_state_e         state_q, state_d;
    logic [FIELD_W:0]   main_q, main_d;
    logic [FIELD_W:0]   skid_q, skid_d;
    logic               hit;
    logic [FIELD_W:0]   payload;
    logic               capture;
    logic               pop;
    logic               unused_msg_parity;

    assign hit     = (mux_control == MATCH_CODE);
    assign payload = {hit, hit ? message[FIELD_LSB +: FIELD_W] : DEFAULT_VAL};
    assign capture = in_valid & in_ready;
    assign pop     = out_valid & out_ready;

    // Bits outside the field are intentionally ignored.
    assign unused_msg_parity = ^message;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BUF_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            BUF_EMPTY: begin
                if (capture) begin
                    state_d = BUF_ONE;
                    main_d  = payload;
                end
            end
            BUF_ONE: begin
                unique case ({capture, pop})
                    2'b10: begin
                        state_d = BUF_TWO;
                        skid_d  = payload;
                    end
                    2'b01: state_d = BUF_EMPTY;
                    2'b11: main_d  = payload;
                    default: ;
                endcase
            end
            BUF_TWO: begin
                // Older entry sits in main; promote the skid entry on pop.
                if (pop) begin
                    state_d = BUF_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q != BUF_EMPTY);
        in_ready  = (state_q != BUF_TWO) & ~rst;
        field     = out_valid ? main_q[FIELD_W-1:0] : DEFAULT_VAL;
        out_hit   = out_valid & main_q[FIELD_W];
    end

`ifdef STAGE5_HIT_CNT_EN
    logic [HIT_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (capture && hit) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_cnt = cnt_q;
`endif

endmodule

// File: rtl/stage5_field_extract.sv
// Top: NUM_CH independent field-extract channels with per-channel skid
// buffers. Defining STAGE5_HIT_CNT_EN adds hit_cnt/cnt_clr ports.
module stage5_field_extract
    import stage5_field_extract_pkg::*;
#(
    parameter int unsigned         NUM_CH      = 3,
    parameter int unsigned         MSG_BITS    = MAX_MESSAGE_BITS,
    parameter int unsigned         CTRL_W      = MESSAGE_MUX_CONTROL_WIDTH,
    parameter int unsigned         FIELD_W     = FIELD_OS2_BITS,
    parameter int unsigned         FIELD_LSB   = Q_OS2_E,
    parameter logic [CTRL_W-1:0]   MATCH_CODE  = MESSAGE_MUX_Q,
    parameter logic [FIELD_W-1:0]  DEFAULT_VAL = DEFAUT_INFOR
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          in_valid,
    output logic [NUM_CH-1:0]          in_ready,
    input  logic [NUM_CH*MSG_BITS-1:0] message,
    input  logic [NUM_CH*CTRL_W-1:0]   mux_control,
    output logic [NUM_CH-1:0]          out_valid,
    input  logic [NUM_CH-1:0]          out_ready,
    output logic [NUM_CH*FIELD_W-1:0]  field,
    output logic [NUM_CH-1:0]          out_hit
`ifdef STAGE5_HIT_CNT_EN
    ,
    output logic [NUM_CH*HIT_CNT_W-1:0] hit_cnt,
    input  logic                        cnt_clr
`endif
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            stage5_field_extract_ch #(
                .MSG_BITS    (MSG_BITS),
                .CTRL_W      (CTRL_W),
                .FIELD_W     (FIELD_W),
                .FIELD_LSB   (FIELD_LSB),
                .MATCH_CODE  (MATCH_CODE),
                .DEFAULT_VAL (DEFAULT_VAL)
            ) u_ch (
                .clk         (clk),
                .rst         (rst),
                .in_valid    (in_valid[gi]),
                .in_ready    (in_ready[gi]),
                .message     (message[gi*MSG_BITS +: MSG_BITS]),
                .mux_control (mux_control[gi*CTRL_W +: CTRL_W]),
                .out_valid   (out_valid[gi]),
                .out_ready   (out_ready[gi]),
                .field       (field[gi*FIELD_W +: FIELD_W]),
                .out_hit     (out_hit[gi])
`ifdef STAGE5_HIT_CNT_EN
                ,
                .cnt_clr     (cnt_clr),
                .hit_cnt     (hit_cnt[gi*HIT_CNT_W +: HIT_CNT_W])
`endif
            );
        end
    endgenerate

endmodule

// File: tb/tb_stage5_field_extract.sv
// Randomized + directed bench for stage5_field_extract against a queue model.
// Build with +define+STAGE5_HIT_CNT_EN to also exercise the hit counters.
module tb_stage5_field_extract;

    localparam int NCH = 3;
    localparam int MB  = 64;
    localparam int CW  = 4;
    localparam int FW  = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [NCH*MB-1:0]    message;
    logic [NCH*CW-1:0]    mux_control;
    logic [NCH-1:0]       out_valid;
    logic [NCH-1:0]       out_ready;
    logic [NCH*FW-1:0]    field;
    logic [NCH-1:0]       out_hit;
`ifdef STAGE5_HIT_CNT_EN
    logic [NCH*16-1:0]    hit_cnt;
    logic                 cnt_clr = 1'b0;
    int unsigned          mcnt[NCH];
`endif

    // Per-channel stimulus
    logic          iv[NCH];
    logic [MB-1:0] msg_a[NCH];
    logic [CW-1:0] ctl_a[NCH];
    logic          ordy[NCH];
    logic          cap_last[NCH];

    // Reference: FIFO contents per channel, each entry {hit, field}
    logic [FW:0]   mq[NCH][$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            in_valid[c]              = iv[c];
            message[c*MB +: MB]      = msg_a[c];
            mux_control[c*CW +: CW]  = ctl_a[c];
            out_ready[c]             = ordy[c];
        end
    end

    stage5_field_extract #(
        .NUM_CH(NCH), .MSG_BITS(MB), .CTRL_W(CW), .FIELD_W(FW),
        .FIELD_LSB(16), .MATCH_CODE(4'h5), .DEFAULT_VAL(8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .message     (message),
        .mux_control (mux_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .field       (field),
        .out_hit     (out_hit)
`ifdef STAGE5_HIT_CNT_EN
        ,
        .hit_cnt     (hit_cnt),
        .cnt_clr     (cnt_clr)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [FW:0] ref_payload(input logic [MB-1:0] m, input logic [CW-1:0] k);
        logic          h;
        logic [MB-1:0] sh;
        h  = (k == 4'h5);
        sh = (m >> 16) & 64'hFF;
        return h ? {1'b1, sh[FW-1:0]} : {1'b0, 8'h00};
    endfunction

    // One clock: check outputs at negedge, advance the model at posedge.
    task automatic step();
        logic cap[NCH];
        logic pop[NCH];
        logic [FW:0] head;
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            int sz;
            sz   = mq[c].size();
            head = (sz != 0) ? mq[c][0] : 9'h000;
            check($sformatf("out_valid[%0d]", c), 64'(out_valid[c]), 64'(sz != 0));
            check($sformatf("in_ready[%0d]", c),  64'(in_ready[c]),  64'(sz < 2));
            check($sformatf("field[%0d]", c),     64'(field[c*FW +: FW]), 64'(head[FW-1:0]));
            check($sformatf("out_hit[%0d]", c),   64'(out_hit[c]),   64'(head[FW]));
`ifdef STAGE5_HIT_CNT_EN
            check($sformatf("hit_cnt[%0d]", c),   64'(hit_cnt[c*16 +: 16]), 64'(mcnt[c]));
`endif
            cap[c] = iv[c] && (sz < 2);
            pop[c] = (sz != 0) && ordy[c];
        end
        @(posedge clk);
        for (int c = 0; c < NCH; c++) begin
            if (pop[c]) void'(mq[c].pop_front());
            if (cap[c]) mq[c].push_back(ref_payload(msg_a[c], ctl_a[c]));
`ifdef STAGE5_HIT_CNT_EN
            if (cnt_clr) mcnt[c] = 0;
            else if (cap[c] && ctl_a[c] == 4'h5 && mcnt[c] < 32'hFFFF) mcnt[c]++;
`endif
            cap_last[c] = cap[c];
        end
        #1;
    endtask

    task automatic set_ch(input int c, input logic v, input logic [7:0] f, input logic [CW-1:0] k);
        iv[c]    = v;
        msg_a[c] = 64'(f) << 16;
        ctl_a[c] = k;
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) begin
            iv[c] = 1'b0; msg_a[c] = '0; ctl_a[c] = '0; ordy[c] = 1'b1; cap_last[c] = 1'b0;
`ifdef STAGE5_HIT_CNT_EN
            mcnt[c] = 0;
`endif
        end

        // Reset state
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(0));
        check("rst_field",     64'(field),     64'(0));
        check("rst_out_hit",   64'(out_hit),   64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 check("post_rst_in_ready", 64'(in_ready), 64'(3'b111));
        step();

        // Hit on ch0, miss on ch1
        set_ch(0, 1'b1, 8'hAB, 4'h5);
        set_ch(1, 1'b1, 8'hAB, 4'h3);
        step();
        set_ch(0, 1'b0, 8'h00, 4'h0);
        set_ch(1, 1'b0, 8'h00, 4'h0);
        check("t1_field0", 64'(field[7:0]), 64'hAB);
        check("t1_hit0",   64'(out_hit[0]), 64'd1);
        check("t2_field1", 64'(field[15:8]), 64'h00);
        check("t2_hit1",   64'(out_hit[1]), 64'd0);
        check("t2_valid1", 64'(out_valid[1]), 64'd1);
        repeat (2) step();

        // Backpressure on ch2
        ordy[2] = 1'b0;
        set_ch(2, 1'b1, 8'd1, 4'h5); step();
        set_ch(2, 1'b1, 8'd2, 4'h5); step();
        set_ch(2, 1'b1, 8'd3, 4'h5); step();
        check("t3_cap_blocked", 64'(cap_last[2]), 64'd0);
        check("t3_in_ready",    64'(in_ready[2]), 64'd0);
        repeat (2) step();
        check("t3_field_held",  64'(field[23:16]), 64'd1);
        ordy[2] = 1'b1;
        for (int k = 0; k < 10 && !cap_last[2]; k++) step();
        check("t3_third_accepted", 64'(cap_last[2]), 64'd1);
        iv[2] = 1'b0;
        repeat (4) step();

        // Simultaneous capture and pop on ch1 in state ONE
        set_ch(1, 1'b1, 8'h11, 4'h5); step();
        set_ch(1, 1'b1, 8'h22, 4'h5); step();
        iv[1] = 1'b0;
        check("t4_in_ready", 64'(in_ready[1]), 64'd1);
        check("t4_field",    64'(field[15:8]), 64'h22);
        check("t4_valid",    64'(out_valid[1]), 64'd1);
        repeat (2) step();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!iv[c] || cap_last[c]) begin
                    iv[c]    = ($urandom_range(0, 3) != 0);
                    msg_a[c] = {$urandom, $urandom};
                    ctl_a[c] = ($urandom_range(0, 1) == 1) ? 4'h5 : 4'($urandom_range(0, 15));
                end
                ordy[c] = ($urandom_range(0, 2) != 0);
            end
            step();
        end

        // Reset with ch0 holding two entries
        for (int c = 0; c < NCH; c++) begin iv[c] = 1'b0; ordy[c] = 1'b1; end
        repeat (3) step();
        ordy[0] = 1'b0;
        set_ch(0, 1'b1, 8'h31, 4'h5); step();
        set_ch(0, 1'b1, 8'h32, 4'h5); step();
        check("t5_two_entries", 64'(mq[0].size()), 64'd2);
        iv[0] = 1'b0;
        rst = 1'b1;
        #1;
        check("t5_out_valid", 64'(out_valid), 64'(0));
        check("t5_field0",    64'(field[7:0]), 64'h00);
        check("t5_out_hit",   64'(out_hit), 64'(0));
        check("t5_in_ready",  64'(in_ready), 64'(0));
`ifdef STAGE5_HIT_CNT_EN
        check("t5_hit_cnt",   64'(hit_cnt), 64'(0));
`endif
        for (int c = 0; c < NCH; c++) begin
            mq[c].delete();
`ifdef STAGE5_HIT_CNT_EN
            mcnt[c] = 0;
`endif
        end
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check("t5_post_in_ready", 64'(in_ready), 64'(3'b111));
        ordy[0] = 1'b1;
        repeat (3) step();

`ifdef STAGE5_HIT_CNT_EN
        // Saturation: ch0 stays in ONE, capturing and popping every cycle
        set_ch(0, 1'b1, 8'h5A, 4'h5);
        repeat (70000) @(posedge clk);
        #1;
        mq[0].push_back(ref_payload(msg_a[0], ctl_a[0]));
        mcnt[0] = 32'hFFFF;
        check("t6_saturated", 64'(hit_cnt[15:0]), 64'hFFFF);
        // Clear coinciding with a hit capture
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        iv[0] = 1'b0;
        check("t6_cleared", 64'(hit_cnt[15:0]), 64'h0);
        repeat (3) step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
